// File: rtl/ram_search_p.sv
// ram_search_p: append-only table with sequential linear key search.
//   Entries are appended one per add. A start scans from entry 0, one
//   entry per cycle, and reports hit/miss plus the matching index. next
//   resumes a scan after the current hit.
//   Optional macro RAM_SEARCH_MASK_EN adds a compare mask, captured on start.
// Ports:
//   clk       clock, all state updates on rising edge
//   reset_n   synchronous active-low reset
//   clear     empty the table and abort any scan
//   add       append x at entry count (only while rdy)
//   start     begin a search for key x from entry 0 (restarts a running scan)
//   next      resume the search after the current hit (DONE with found only)
//   x         append data / search key
//   mask      (RAM_SEARCH_MASK_EN only) compare mask, 1 = bit participates
//   rdy       high when not scanning; found/index are valid while high
//   found     last completed search hit
//   index     entry of the hit; holds its last value otherwise
//   count     number of valid entries (0..DEPTH)
//   full      count == DEPTH
//   empty     count == 0
//   overflow  sticky, set by an add attempted while full
module ram_search_p #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              add,
  input  logic              start,
  input  logic              next,
  input  logic [DATA_W-1:0] x,
`ifdef RAM_SEARCH_MASK_EN
  input  logic [DATA_W-1:0] mask,
`endif
  output logic              rdy,
  output logic              found,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_key, w_key_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_index, w_index_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_found, w_found_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_rdy;
  logic              w_we;
  logic              w_match;
  logic              w_full;
  logic [ADDR_W-1:0] w_last_idx;

`ifdef RAM_SEARCH_MASK_EN
  logic [DATA_W-1:0] r_key_mask, w_key_mask_nxt;
  assign w_match = ((r_mem[r_ptr] ^ r_key) & r_key_mask) == '0;
`else
  assign w_match = (r_mem[r_ptr] == r_key);
`endif

  // Highest valid entry; only used while count > 0.
  assign w_last_idx = ADDR_W'(r_count - (ADDR_W+1)'(1));
  assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));

  // Next-state and datapath; priority clear > start > scan/next > add.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_nxt      = r_key;
    w_ptr_nxt      = r_ptr;
    w_index_nxt    = r_index;
    w_count_nxt    = r_count;
    w_found_nxt    = r_found;
    w_overflow_nxt = r_overflow;
    w_we           = 1'b0;
`ifdef RAM_SEARCH_MASK_EN
    w_key_mask_nxt = r_key_mask;
`endif
    if (clear) begin
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
      w_found_nxt    = 1'b0;
      w_state_nxt    = S_IDLE;
    end else if (start) begin
      w_key_nxt   = x;
`ifdef RAM_SEARCH_MASK_EN
      w_key_mask_nxt = mask;
`endif
      w_ptr_nxt   = '0;
      w_found_nxt = 1'b0;
      w_state_nxt = (r_count == '0) ? S_DONE : S_SCAN;
    end else if (r_state == S_SCAN) begin
      // add and next are ignored while scanning
      if (w_match) begin
        w_found_nxt = 1'b1;
        w_index_nxt = r_ptr;
        w_state_nxt = S_DONE;
      end else if (r_ptr == w_last_idx) begin
        w_found_nxt = 1'b0;
        w_state_nxt = S_DONE;
      end else begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
      end
    end else if (next && (r_state == S_DONE) && r_found) begin
      w_found_nxt = 1'b0;
      if (r_index != w_last_idx) begin
        w_ptr_nxt   = r_index + ADDR_W'(1);
        w_state_nxt = S_SCAN;
      end
    end else if (add) begin
      if (w_full) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_we        = 1'b1;
        w_count_nxt = r_count + (ADDR_W+1)'(1);
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_ptr      <= '0;
      r_index    <= '0;
      r_count    <= '0;
      r_found    <= 1'b0;
      r_overflow <= 1'b0;
      r_rdy      <= 1'b1;
`ifdef RAM_SEARCH_MASK_EN
      r_key_mask <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_key      <= w_key_nxt;
      r_ptr      <= w_ptr_nxt;
      r_index    <= w_index_nxt;
      r_count    <= w_count_nxt;
      r_found    <= w_found_nxt;
      r_overflow <= w_overflow_nxt;
      r_rdy      <= (w_state_nxt != S_SCAN);
`ifdef RAM_SEARCH_MASK_EN
      r_key_mask <= w_key_mask_nxt;
`endif
    end
  end

  // Table storage is not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_count[ADDR_W-1:0]] <= x;
    end
  end

  assign rdy      = r_rdy;
  assign found    = r_found;
  assign index    = r_index;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = (r_count == '0);
  assign overflow = r_overflow;

endmodule

// File: doc/ram_search_p.md
Name: ram_search_p

Overview:
- Parametrised successor of the single-port append/linear-search block.
- Holds a DATA_W x DEPTH internal store. Entries are appended sequentially, then scanned for a key one entry per cycle.
- Reports hit/miss and the matching index. Supports find-next continuation, clear, full/empty/overflow status, and a compile-time masked-compare mode.
- Sits beside a controller that loads a table and issues lookups with a start/rdy handshake.

Parameters:
- DATA_W, 8, width of stored words and key.
- DEPTH, 16, number of entries (power of two, >=2).
- ADDR_W, $clog2(DEPTH), index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- clear  in  1  empty the table, abort any search
- add  in  1  append x at entry count
- start  in  1  begin search for key x from entry 0
- next  in  1  resume search after current hit
- x  in  DATA_W  append data / search key
- rdy  out  1  high when not scanning; found/index valid when high
- found  out  1  last completed search hit
- index  out  ADDR_W  entry of hit; holds last value otherwise
- count  out  ADDR_W+1  number of valid entries (0..DEPTH)
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: add attempted while full

Behaviour:
- Reset (reset_n low at clk edge) is a synchronous clear. Results: state IDLE, count=0, rdy=1, found=0, index=0, overflow=0, key=0. Memory contents are not cleared.
- States: IDLE, SCAN, DONE. rdy=1 in IDLE/DONE, 0 in SCAN.
- Priority per cycle: reset > clear > start > next > add.
- clear:
  - count<=0, overflow<=0, found<=0, state<=IDLE. Any scan is aborted.
- add:
  - Accepted only when rdy=1 and no higher-priority op.
  - Not full: mem[count]<=x, count<=count+1.
  - Full: no write, overflow<=1.
  - add while rdy=0: ignored, overflow unchanged.
- start:
  - Accepted in any state, including mid-SCAN, which restarts the search.
  - key<=x, ptr<=0, found<=0.
  - count==0: state<=DONE, found stays 0.
  - Otherwise: state<=SCAN.
- SCAN, once per cycle:
  - Compare mem[ptr] with key (combinational read).
  - Match: found<=1, index<=ptr, state<=DONE.
  - Else if ptr==count-1: found<=0, state<=DONE.
  - Else: ptr<=ptr+1.
- Latency: hit at entry k gives rdy=1 exactly k+1 cycles after the start edge. Miss gives rdy=1 count cycles after the start edge.
- next:
  - Only honoured in DONE with found=1.
  - index==count-1: found<=0, stay DONE (one cycle).
  - Else: ptr<=index+1, found<=0, state<=SCAN.
  - Ignored in IDLE, SCAN, or DONE with found=0.
- add during DONE is allowed. It does not change found/index, and later next scans include the new entry.
- Arithmetic:
  - count is ADDR_W+1 bits and never wraps past DEPTH.
  - ptr is ADDR_W bits; wrap is impossible because the scan terminates at count-1.
- full/empty/count are combinational from the count register.

Optional Feature:
- Macro: RAM_SEARCH_MASK_EN.
- Defined:
  - Extra input port mask [DATA_W], registered into key_mask on start.
  - Match rule: ((mem[ptr] ^ key) & key_mask)==0. A mask of all zeros matches entry 0 immediately when count>0.
- Undefined:
  - No mask port.
  - Exact equality compare.
  - Otherwise identical timing.

Test Plan:
- Reset, then add 0x11,0x22,0x33,0x44 -> count=4, empty=0, full=0. start x=0x33 -> rdy low 3 cycles, then found=1, index=2.
- Same table, start x=0x99 -> rdy low 4 cycles, then found=0. Repeat with count=0 -> rdy stays 1, found=0 the cycle after start.
- Store 0xAA at entries 1 and 3 (of 4). start 0xAA -> index=1. next -> index=3, found=1. next -> found=0, rdy=1 within 1 cycle.
- Fill DEPTH=16 entries -> full=1. add again -> count stays 16, overflow=1. clear -> count=0, overflow=0, empty=1.
- Mid-SCAN, pulse start with a new key -> scan restarts from 0 with the new key. Mid-SCAN, pulse clear -> rdy=1, found=0, count=0. Hold reset_n low during SCAN -> all outputs at reset values next edge.
- With RAM_SEARCH_MASK_EN: table 0x5A,0x3C; start x=0x0C, mask=0x0F -> index=1. With mask=0x00 -> index=0.
